// File: rtl/fp_conv_arbiter_pkg.sv
// Shared floating-point definitions: the arbiter FSM states, the op encoding
// and the IEEE half-precision field layout used by the converters and the
// saturation logic.
package fp_conv_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Operation encoding carried on rN_op
    localparam logic OP_I2H = 1'b0;   // unsigned integer -> half
    localparam logic OP_H2I = 1'b1;   // half -> unsigned integer

    // Half-precision field positions
    localparam int HALF_SIGN   = 15;
    localparam int HALF_EXP_HI = 14;
    localparam int HALF_EXP_LO = 10;
    localparam int HALF_MAN_HI = 9;
    localparam int HALF_MAN_LO = 0;

    localparam logic [4:0] EXP_MAX  = 5'd31;
    localparam logic [4:0] EXP_BIAS = 5'd15;

endpackage

// File: rtl/fp_half2int.sv
// IEEE half to unsigned 16-bit integer, truncating toward zero.
// Raw behaviour: the sign is ignored (magnitude is returned), subnormals and
// values below 1.0 give 0, and inf/NaN give 0.
module fp_half2int
    import fp_conv_arbiter_pkg::*;
(
    input  logic [15:0] half_in,
    output logic [15:0] int_out
);

    logic [4:0]  exp_f;
    logic [3:0]  sh;
    logic [25:0] sig;

    // Shift the significand left by the unbiased exponent and drop the fraction
    always_comb begin
        exp_f   = half_in[HALF_EXP_HI:HALF_EXP_LO];
        sh      = '0;
        sig     = '0;
        int_out = '0;
        if (exp_f >= EXP_BIAS && exp_f != EXP_MAX) begin
            sh      = 4'(exp_f - EXP_BIAS);
            sig     = {15'd0, 1'b1, half_in[HALF_MAN_HI:HALF_MAN_LO]} << sh;
            int_out = 16'(sig >> 10);
        end
    end

endmodule

// File: rtl/fp_int2half.sv
// Unsigned 16-bit integer to IEEE half, round-to-nearest-even.
// Values that round past the largest finite half (65504) become +inf.
module fp_int2half
    import fp_conv_arbiter_pkg::*;
(
    input  logic [15:0] int_in,
    output logic [15:0] half_out
);

    logic [3:0]  msb;
    logic [3:0]  sh4;
    logic [9:0]  man_exact;
    logic [11:0] keep;
    logic [15:0] low_mask;
    logic        guard;
    logic        sticky;
    logic        rnd;
    logic [11:0] sum;
    logic [4:0]  exp_f;

    // Normalise on the leading one, then round away the bits below the mantissa
    always_comb begin
        msb       = '0;
        sh4       = '0;
        man_exact = '0;
        keep      = '0;
        low_mask  = '0;
        guard     = 1'b0;
        sticky    = 1'b0;
        rnd       = 1'b0;
        sum       = '0;
        exp_f     = '0;
        half_out  = '0;
        for (int i = 0; i < 16; i++) begin
            if (int_in[i]) msb = 4'(i);
        end
        if (int_in != 16'd0) begin
            if (msb <= 4'd10) begin
                // Fits in the mantissa exactly, no rounding needed
                man_exact = 10'(int_in << (4'd10 - msb));
                half_out  = {1'b0, {1'b0, msb} + EXP_BIAS, man_exact};
            end else begin
                sh4      = msb - 4'd10;
                keep     = 12'(int_in >> sh4);
                guard    = int_in[sh4 - 4'd1];
                low_mask = (16'd1 << (sh4 - 4'd1)) - 16'd1;
                sticky   = |(int_in & low_mask);
                rnd      = guard & (sticky | keep[0]);
                sum      = keep + {11'd0, rnd};
                // A carry out of the rounding bumps the exponent; low bits are then 0
                exp_f    = {1'b0, msb} + EXP_BIAS + {4'd0, sum[11]};
                if (exp_f == EXP_MAX)
                    half_out = 16'h7C00;
                else
                    half_out = {1'b0, exp_f, 10'(sum)};
            end
        end
    end

endmodule

// File: rtl/fp_rr_arb2.sv
// Two-way round-robin grant. A lone request is granted; on contention the
// pointer decides. After any grant the pointer moves to the other requester.
module fp_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_reg;
    logic ptr_next;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt[gi] = en & req[gi] & (~req[1-gi] | (ptr_reg == 1'(gi)));
        end
    endgenerate

    // Point at the requester that was not just served
    always_comb begin
        ptr_next = ptr_reg;
        if (gnt[0])
            ptr_next = 1'b1;
        else if (gnt[1])
            ptr_next = 1'b0;
    end

    // Pointer register, cleared to requester 0 on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_reg <= 1'b0;
        else
            ptr_reg <= ptr_next;
    end

endmodule

// File: rtl/fp_conv_arbiter.sv
// Two-requester arbiter in front of a shared int<->half converter pair.
// One request is in flight at a time: accept, wait CONV_LAT cycles, hold the
// response until the consumer takes it.
// Optional macro FP_CONV_SAT_EN: clamp half-to-int results (negative nonzero
// -> 0, inf/NaN -> 16'hFFFF) and flag the clamp on rsp_sat.
module fp_conv_arbiter #(
    parameter int CONV_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic        r0_op,
    input  logic [15:0] r0_data,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic        r1_op,
    input  logic [15:0] r1_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_sat
);

    import fp_conv_arbiter_pkg::*;

    localparam logic [2:0] CNT_INIT = 3'(CONV_LAT - 1);

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic        op_reg, op_next;
    logic [15:0] opnd_reg, opnd_next;
    logic        id_reg, id_next;

    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        arb_en;
    logic [15:0] i2h_res;
    logic [15:0] h2i_res;
    logic [15:0] conv_res;
    logic        conv_sat;

    // Ready is only offered in IDLE and never while reset is held
    assign req    = {r1_valid, r0_valid};
    assign arb_en = (state_reg == ST_IDLE) && rst_n;

    fp_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   (req),
        .gnt   (gnt)
    );

    assign r0_ready = gnt[0];
    assign r1_ready = gnt[1];

    // Both converters look only at the captured operand
    fp_int2half u_i2h (
        .int_in   (opnd_reg),
        .half_out (i2h_res)
    );

    fp_half2int u_h2i (
        .half_in (opnd_reg),
        .int_out (h2i_res)
    );

`ifdef FP_CONV_SAT_EN
    // Select by captured op, clamping out-of-range half-to-int inputs
    always_comb begin
        conv_res = i2h_res;
        conv_sat = 1'b0;
        case (op_reg)
            OP_I2H: conv_res = i2h_res;
            OP_H2I: begin
                conv_res = h2i_res;
                if (opnd_reg[HALF_SIGN] && (opnd_reg[HALF_SIGN-1:0] != 15'd0)) begin
                    conv_res = 16'h0000;
                    conv_sat = 1'b1;
                end else if (opnd_reg[HALF_EXP_HI:HALF_EXP_LO] == EXP_MAX) begin
                    conv_res = 16'hFFFF;
                    conv_sat = 1'b1;
                end
            end
            default: conv_res = i2h_res;
        endcase
    end
`else
    // Select by captured op; raw converter output, never saturated
    always_comb begin
        conv_res = i2h_res;
        case (op_reg)
            OP_I2H:  conv_res = i2h_res;
            OP_H2I:  conv_res = h2i_res;
            default: conv_res = i2h_res;
        endcase
    end
    assign conv_sat = 1'b0;
`endif

    // Next-state: accept and capture in IDLE, count down in BUSY, wait for consumer in DONE
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        opnd_next  = opnd_reg;
        id_next    = id_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|gnt) begin
                    state_next = ST_BUSY;
                    cnt_next   = CNT_INIT;
                    id_next    = gnt[1];
                    op_next    = gnt[1] ? r1_op   : r0_op;
                    opnd_next  = gnt[1] ? r1_data : r0_data;
                end
            end
            ST_BUSY: begin
                if (cnt_reg == 3'd0)
                    state_next = ST_DONE;
                else
                    cnt_next = cnt_reg - 3'd1;
            end
            ST_DONE: begin
                if (rsp_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and captured request; reset discards anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 3'd0;
            op_reg    <= 1'b0;
            opnd_reg  <= 16'd0;
            id_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            opnd_reg  <= opnd_next;
            id_reg    <= id_next;
        end
    end

    // Response is driven only in DONE and forced to zero otherwise
    assign rsp_valid = (state_reg == ST_DONE);
    assign rsp_id    = rsp_valid & id_reg;
    assign rsp_data  = rsp_valid ? conv_res : 16'd0;
    assign rsp_sat   = rsp_valid & conv_sat;

endmodule

// File: tb/tb_fp_conv_arbiter.sv
// Self-checking bench for fp_conv_arbiter: main instance at CONV_LAT=2 with
// directed and random transactions, plus CONV_LAT=1 and CONV_LAT=8 instances
// for latency boundaries. Honours FP_CONV_SAT_EN in its reference model.
module tb_fp_conv_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_valid = 1'b0, r0_op = 1'b0, r1_valid = 1'b0, r1_op = 1'b0;
    logic [15:0] r0_data = 16'd0, r1_data = 16'd0;
    logic        rsp_ready = 1'b0;
    logic        r0_ready, r1_ready, rsp_valid, rsp_id, rsp_sat;
    logic [15:0] rsp_data;

    // Latency-boundary instances: index 0 is CONV_LAT=1, index 1 is CONV_LAT=8
    logic [1:0]  xv = 2'b00, xop = 2'b00, xrr = 2'b00;
    logic [15:0] xd [2];
    logic [1:0]  x_r0_ready, x_r1_ready, x_rv, x_id, x_sat;
    logic [15:0] x_rd [2];
    logic        tie0 = 1'b0;
    logic [15:0] tie16 = 16'd0;

    int n_check = 0;
    int n_fail  = 0;
    int tb_ptr  = 0;
    int txn_no  = 0;

    always #5 clk = ~clk;

    fp_conv_arbiter #(.CONV_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_data(r0_data),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_data(r1_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_sat(rsp_sat)
    );

    fp_conv_arbiter #(.CONV_LAT(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(xv[0]), .r0_ready(x_r0_ready[0]), .r0_op(xop[0]), .r0_data(xd[0]),
        .r1_valid(tie0), .r1_ready(x_r1_ready[0]), .r1_op(tie0), .r1_data(tie16),
        .rsp_valid(x_rv[0]), .rsp_ready(xrr[0]), .rsp_id(x_id[0]),
        .rsp_data(x_rd[0]), .rsp_sat(x_sat[0])
    );

    fp_conv_arbiter #(.CONV_LAT(8)) dut_l8 (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(xv[1]), .r0_ready(x_r0_ready[1]), .r0_op(xop[1]), .r0_data(xd[1]),
        .r1_valid(tie0), .r1_ready(x_r1_ready[1]), .r1_op(tie0), .r1_data(tie16),
        .rsp_valid(x_rv[1]), .rsp_ready(xrr[1]), .rsp_id(x_id[1]),
        .rsp_data(x_rd[1]), .rsp_sat(x_sat[1])
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Integer -> half by arithmetic: find the power of two, scale, round half to even
    function automatic logic [15:0] ref_i2h(input logic [15:0] x);
        int e;
        longint num, den, q, r;
        if (x == 16'd0) return 16'd0;
        e = 0;
        while ((longint'(1) << (e + 1)) <= longint'(x)) e++;
        num = longint'(x) * 1024;
        den = longint'(1) << e;
        q = num / den;
        r = num % den;
        if ((2 * r > den) || ((2 * r == den) && (q % 2 == 1))) q++;
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        if (e + 15 >= 31) return 16'h7C00;
        return {1'b0, 5'(e + 15), 10'(q - 1024)};
    endfunction

    // Half -> integer by arithmetic: value = (1024+m) * 2^(e-15) / 1024, truncated
    function automatic logic [15:0] ref_h2i(input logic [15:0] h, output logic sat);
        int e, m;
        longint mag;
        e = int'(h[14:10]);
        m = int'(h[9:0]);
        sat = 1'b0;
        if (e == 31 || e < 15) mag = 0;
        else mag = (longint'(1024 + m) * (longint'(1) << (e - 15))) / 1024;
`ifdef FP_CONV_SAT_EN
        if (h[15] && h[14:0] != 15'd0) begin
            sat = 1'b1;
            return 16'd0;
        end
        if (e == 31) begin
            sat = 1'b1;
            return 16'hFFFF;
        end
`endif
        return mag[15:0];
    endfunction

    function automatic int model_grant(input logic v0, input logic v1);
        if (v0 && v1) return tb_ptr;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic scramble();
        r0_data  = 16'($urandom);
        r1_data  = 16'($urandom);
        r0_op    = 1'($urandom);
        r1_op    = 1'($urandom);
        r0_valid = 1'($urandom);
        r1_valid = 1'($urandom);
    endtask

    // One request/response transaction on the main instance
    task automatic run_txn(input logic v0, input logic op0, input logic [15:0] d0,
                           input logic v1, input logic op1, input logic [15:0] d1,
                           input int stall);
        int g, g2, lat;
        logic        op_s;
        logic [15:0] d_s, exp_d;
        logic        exp_s;
        @(negedge clk);
        r0_valid = v0; r0_op = op0; r0_data = d0;
        r1_valid = v1; r1_op = op1; r1_data = d1;
        rsp_ready = 1'b0;
        #1;
        g = model_grant(v0, v1);
        check_val("r0_ready_idle", r0_ready, g == 0);
        check_val("r1_ready_idle", r1_ready, g == 1);
        check_val("idle_rsp_valid", rsp_valid, 0);
        if (g < 0) return;
        op_s = (g == 0) ? op0 : op1;
        d_s  = (g == 0) ? d0 : d1;
        exp_s = 1'b0;
        if (op_s == 1'b0) exp_d = ref_i2h(d_s);
        else exp_d = ref_h2i(d_s, exp_s);
        tb_ptr = 1 - g;
        @(posedge clk); #1;
        scramble();
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            check_val("busy_ready", {r1_ready, r0_ready}, 0);
            check_val("busy_rsp_data", {rsp_sat, rsp_data}, 0);
            @(posedge clk); #1;
            lat++;
            scramble();
        end
        check_val("latency", lat, LAT);
        check_val("rsp_data", rsp_data, exp_d);
        check_val("rsp_id", rsp_id, g);
        check_val("rsp_sat", rsp_sat, exp_s);
        check_val("done_ready", {r1_ready, r0_ready}, 0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            scramble();
            check_val("hold_valid", rsp_valid, 1);
            check_val("hold_data", {rsp_id, rsp_sat, rsp_data}, {g[0], exp_s, exp_d});
            check_val("hold_ready", {r1_ready, r0_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        // Back in IDLE with whatever valids are up: no accept happened on the handshake edge
        g2 = model_grant(r0_valid, r1_valid);
        check_val("post_hs_ready", {r1_ready, r0_ready}, {g2 == 1, g2 == 0});
        rsp_ready = 1'b0;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        check_val("post_hs_rsp", {rsp_valid, rsp_sat, rsp_data}, 0);
        $display("txn %0d: id=%0d op=%0d opnd=%04h rsp=%04h sat=%0d lat=%0d stall=%0d",
                 txn_no, g, op_s, d_s, rsp_data, exp_s, lat, stall);
        txn_no++;
    endtask

    // Latency and result check on one of the boundary instances
    task automatic lat_test(input int k, input int exp_lat);
        logic [15:0] d;
        int lat;
        d = 16'($urandom);
        @(negedge clk);
        xv[k] = 1'b1;
        xd[k] = d;
        #1;
        check_val("x_ready", x_r0_ready[k], 1);
        @(posedge clk); #1;
        xv[k] = 1'b0;
        xd[k] = 16'($urandom);
        lat = 0;
        while (!x_rv[k] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("x_latency", lat, exp_lat);
        check_val("x_data", x_rd[k], ref_i2h(d));
        check_val("x_id_sat_r1", {x_id[k], x_sat[k], x_r1_ready[k]}, 0);
        xrr[k] = 1'b1;
        @(posedge clk); #1;
        xrr[k] = 1'b0;
        check_val("x_rsp_drop", x_rv[k], 0);
        $display("txn lat%0d: opnd=%04h rsp=%04h lat=%0d", exp_lat, d, x_rd[k], lat);
    endtask

    initial begin
        int seen;
        logic [15:0] hd;
        xd[0] = 16'd0;
        xd[1] = 16'd0;
        // Reset state with requests pending: everything must be quiet
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_outputs", {r0_ready, r1_ready, rsp_valid, rsp_id, rsp_sat, rsp_data}, 0);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rst_n = 1'b1;
        tb_ptr = 0;

        // Contention from reset: grants alternate r0, r1, r0, r1
        for (int i = 0; i < 4; i++) run_txn(1'b1, 1'b0, 16'd17, 1'b1, 1'b0, 16'd1, 0);
        // Lone requester, int-to-half
        run_txn(1'b1, 1'b0, 16'd256, 1'b0, 1'b0, 16'd0, 0);
        // Half-to-int with a long consumer stall
        run_txn(1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'h5C00, 5);
        // Saturation candidates and rounding edges
        run_txn(1'b1, 1'b1, 16'h7C00, 1'b0, 1'b0, 16'd0, 1);
        run_txn(1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'hBC00, 1);
        run_txn(1'b1, 1'b1, 16'h8000, 1'b0, 1'b0, 16'd0, 0);
        run_txn(1'b1, 1'b1, 16'h7BFF, 1'b0, 1'b0, 16'd0, 0);
        run_txn(1'b1, 1'b1, 16'h3BFF, 1'b0, 1'b0, 16'd0, 0);
        run_txn(1'b1, 1'b0, 16'd65535, 1'b0, 1'b0, 16'd0, 0);
        run_txn(1'b1, 1'b0, 16'd65504, 1'b0, 1'b0, 16'd0, 0);
        run_txn(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd2049, 0);
        run_txn(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd2051, 0);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom), 1'($urandom), 16'($urandom),
                    1'($urandom), 1'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset mid-BUSY (mode 0) and mid-DONE (mode 1) after r0 moved the pointer to r1
        for (int mode = 0; mode < 2; mode++) begin
            @(negedge clk);
            r0_valid = 1'b1; r0_op = 1'b0; r0_data = 16'd300;
            r1_valid = 1'b0;
            #1;
            check_val("pre_rst_ready", r0_ready, model_grant(1'b1, 1'b0) == 0);
            @(posedge clk); #1;
            tb_ptr = 0;
            r1_valid = 1'b1;
            if (mode == 1) begin
                for (int c = 0; c < 20 && !rsp_valid; c++) begin
                    @(posedge clk); #1;
                end
                check_val("pre_rst_valid", rsp_valid, 1);
            end
            #2;
            rst_n = 1'b0;
            #1;
            check_val("async_rst_out", {r0_ready, r1_ready, rsp_valid, rsp_id, rsp_sat, rsp_data}, 0);
            repeat (2) @(posedge clk);
            @(negedge clk);
            r0_valid = 1'b0;
            r1_valid = 1'b0;
            rst_n = 1'b1;
            seen = 0;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); #1;
                if (rsp_valid) seen++;
            end
            check_val("no_rsp_after_rst", seen, 0);
            hd = 16'($urandom_range(1, 1000));
            run_txn(1'b1, 1'b0, hd, 1'b1, 1'b0, 16'd5, 0);
        end

        // Latency boundaries
        for (int i = 0; i < 2; i++) begin
            lat_test(0, 1);
            lat_test(1, 8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_check, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_check);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp_conv_arbiter.md
FP_CONV_ARBITER -- requirements
Module: fp_conv_arbiter

Interface
REQ-001 SHALL have parameter CONV_LAT, default 2: cycles from request accept to rsp_valid; legal range 1..8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports r0_valid/r1_valid, input, 1 bit each: requester 0/1 holds a request.
REQ-005 SHALL have ports r0_ready/r1_ready, output, 1 bit each: request accepted this cycle when valid and ready are both high.
REQ-006 SHALL have ports r0_op/r1_op, input, 1 bit each: 0 = int-to-half conversion, 1 = half-to-int conversion.
REQ-007 SHALL have ports r0_data/r1_data, input, 16 bits each: operand, either an unsigned integer or an IEEE half.
REQ-008 SHALL have port rsp_valid, output, 1 bit: result available.
REQ-009 SHALL have port rsp_ready, input, 1 bit: consumer takes the result.
REQ-010 SHALL have port rsp_id, output, 1 bit: index of the requester that owns the result.
REQ-011 SHALL have port rsp_data, output, 16 bits: conversion result.
REQ-012 SHALL have port rsp_sat, output, 1 bit: result was clamped.

Function
REQ-013 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-014 In IDLE, SHALL assert ready combinationally to exactly one valid requester; ready SHALL be low in BUSY and DONE.
REQ-015 Arbitration SHALL follow these rules: a lone valid requester is granted; when both are valid, the requester matching the round-robin pointer is granted; the pointer moves to the other requester after every accept.
REQ-016 On accept, SHALL capture op, data and id, then go to BUSY with counter = CONV_LAT-1.
REQ-017 In BUSY, SHALL decrement the counter each cycle and go to DONE when it reaches 0 (CONV_LAT=1 goes straight to DONE); accept at edge N gives rsp_valid high after edge N+CONV_LAT.
REQ-018 In DONE, SHALL hold rsp_valid, rsp_id, rsp_data and rsp_sat stable until rsp_ready is high; then go to IDLE.
REQ-019 No new accept SHALL occur in the cycle of the response handshake; the earliest next accept is the following cycle.
REQ-020 Conversion SHALL use the captured operand only; later changes on rN_data SHALL NOT affect the in-flight result.
REQ-021 Requests not yet accepted SHALL NOT be stored; a requester dropping valid before ready SHALL lose its request.
REQ-022 rsp_data SHALL be 0 and rsp_sat SHALL be 0 whenever rsp_valid is low.

Reset
REQ-023 On rst_n low, SHALL go to IDLE immediately: pointer = 0, counter = 0, captured operand = 0; rsp_valid, rsp_id, rsp_data, rsp_sat and ready all 0.
REQ-024 Reset mid-BUSY or mid-DONE SHALL discard the in-flight result, with no response emitted after reset.
REQ-025 After rst_n rises, the first grant with both requesters valid SHALL go to requester 0.

Configuration
REQ-026 With macro FP_CONV_SAT_EN defined, half-to-int results SHALL be clamped as follows; a clamp SHALL set rsp_sat=1:
- negative nonzero input -> 0
- exponent field 31 (inf/NaN) -> 16'hFFFF
REQ-027 Without FP_CONV_SAT_EN, the raw converter output SHALL pass through unchanged and rsp_sat SHALL be tied 0; the port list SHALL NOT change.

Structure
REQ-028 SHALL put the following in the shared floating-point package: the FSM state enum, the op encoding constants, and half-field constants (sign bit 15, exponent 14:10, mantissa 9:0, EXP_MAX = 31).
REQ-029 SHALL instantiate the existing int-to-half and half-to-int converters, fed from the captured operand, and select between them by the captured op.
REQ-030 SHALL have one natural sub-module, fp_rr_arb2: the 2-way round-robin grant logic.

Verification
REQ-031 r0: op=0, data=256, alone, CONV_LAT=2 -> r0_ready in the same cycle; rsp_valid 2 cycles later with rsp_data=16'h5C00, rsp_id=0.
REQ-032 r0 and r1 both valid continuously, each op=0, data 17 and 1 -> grants alternate r0, r1, r0, ... with results 16'h4C40 (id 0) and 16'h3C00 (id 1).
REQ-033 r1: op=1, data=16'h5C00, rsp_ready held low 5 cycles -> rsp_valid and rsp_data=256 stable for all 5 cycles; r0_ready and r1_ready stay 0 throughout.
REQ-034 With FP_CONV_SAT_EN, op=1 on 16'h7C00 and on 16'hBC00 -> 16'hFFFF with rsp_sat=1, and 0 with rsp_sat=1; without the macro, rsp_sat=0 for both.
REQ-035 rst_n pulsed low during BUSY -> all outputs 0 asynchronously; no rsp_valid afterwards; first grant with both requesters valid goes to r0.
REQ-036 CONV_LAT=1 and CONV_LAT=8 -> rsp_valid exactly 1 and 8 cycles after accept respectively.
